// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display
//  Description : Drives a 4-digit common-anode seven-segment display from the
//                stopwatch BCD digits. The digits are scanned one at a time.
//                A snapshot taken once per frame keeps each frame coherent.
//                In adjustment mode the selected digit blinks.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned C_RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned C_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [C_RW-1:0] C_REF_LAST   = C_RW'(REFRESH_DIV - 1);
  localparam logic [C_BW-1:0] C_BLINK_LAST = C_BW'(BLINK_DIV - 1);
  localparam logic [6:0]      C_SEG_BLANK  = 7'b1111111;

  logic [C_RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_q, snap_d;
  logic [C_BW-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_off_q, blink_off_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;

  logic            ref_wrap;
  logic [3:0]      digit;
  logic            blank;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    decode7 = 7'b1000000;
      4'd1:    decode7 = 7'b1111001;
      4'd2:    decode7 = 7'b0100100;
      4'd3:    decode7 = 7'b0110000;
      4'd4:    decode7 = 7'b0011001;
      4'd5:    decode7 = 7'b0010010;
      4'd6:    decode7 = 7'b0000010;
      4'd7:    decode7 = 7'b1111000;
      4'd8:    decode7 = 7'b0000000;
      4'd9:    decode7 = 7'b0010000;
      default: decode7 = 7'b0111111;
    endcase
  endfunction

  // Scan counter, frame snapshot and blink timer next-state logic
  always_comb begin
    ref_wrap    = (ref_cnt_q == C_REF_LAST);
    ref_cnt_d   = ref_wrap ? '0 : ref_cnt_q + C_RW'(1);
    idx_d       = ref_wrap ? idx_q + 2'd1 : idx_q;
    snap_d      = snap_q;
    if (ref_wrap && (idx_q == 2'd3)) begin
      snap_d = {min_tens, min_ones, sec_tens, sec_ones};
    end
    // Leaving adjust mode clears the timer so re-entry starts visible
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (ADJ) begin
      if (blink_cnt_q == C_BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + C_BW'(1);
        blink_off_d = blink_off_q;
      end
    end
  end

  // Output decode for the digit currently addressed by idx
  always_comb begin
    case (idx_q)
      2'd0:    digit = snap_q[3:0];
      2'd1:    digit = snap_q[7:4];
      2'd2:    digit = snap_q[11:8];
      default: digit = snap_q[15:12];
    endcase
    // ADJ and SEL act live; SEL shares the anode index encoding
    blank = ADJ && blink_off_q && (idx_q == SEL);
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? C_SEG_BLANK : decode7(digit);
    dp_d  = ((idx_q == 2'd2) && !blank) ? 1'b0 : 1'b1;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      ref_cnt_q   <= '0;
      idx_q       <= 2'd0;
      snap_q      <= 16'd0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      seg_q       <= C_SEG_BLANK;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_display
//  Description : Self-checking bench for stopwatch_display with small dividers.
//                Expected display words are queued as each cycle is driven and
//                popped after the clock edge that should produce them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_display;

  localparam int RD = 4;
  localparam int BD = 16;

  logic       clk_c = 1'b0;
  logic       reset_c = 1'b1;
  logic       ADJ = 1'b0;
  logic [1:0] SEL = 2'd0;
  logic [3:0] min_tens = 4'd0, min_ones = 4'd0, sec_tens = 4'd0, sec_ones = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk_c(clk_c), .reset_c(reset_c), .ADJ(ADJ), .SEL(SEL),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk_c = ~clk_c;

  int          checks = 0;
  int          passes = 0;
  int          e = 0;           // clock edges since reset release
  int          j = 0;           // consecutive edges with ADJ high
  logic [15:0] shown = 16'd0;   // digits latched at the last frame boundary
  logic [11:0] q[$];            // expected {an, seg, dp}
  logic [11:0] x;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;  4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;  4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;  4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;  4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;  4'd9: seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  // Display word the next edge should produce, from slot/frame/blink-half view
  function automatic logic [11:0] predict();
    int         slot;
    logic       blank;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    slot  = (e / RD) % 4;
    blank = ADJ && (((j / BD) % 2) == 1) && (slot == int'(SEL));
    a     = ~(4'b0001 << slot);
    s     = blank ? 7'b1111111 : seg_of(shown[slot*4 +: 4]);
    p     = (slot == 2 && !blank) ? 1'b0 : 1'b1;
    return {a, s, p};
  endfunction

  function automatic bit blank_next();
    return ADJ && (((j / BD) % 2) == 1) && (((e / RD) % 4) == int'(SEL));
  endfunction

  task automatic tick();
    q.push_back(predict());
    if (((e + 1) % (4 * RD)) == 0) shown = {min_tens, min_ones, sec_tens, sec_ones};
    j = ADJ ? j + 1 : 0;
    e = e + 1;
    @(posedge clk_c);
    #1;
  endtask

  task automatic restart_model();
    e = 0;
    j = 0;
    shown = 16'd0;
  endtask

  task automatic test_reset();
    reset_c = 1'b1;
    repeat (3) @(posedge clk_c);
    #1;
    checks++; if (an !== 4'b1111) $display("FAIL reset_an got=%b exp=1111", an); else passes++;
    checks++; if (seg !== 7'b1111111) $display("FAIL reset_seg got=%b exp=1111111", seg); else passes++;
    checks++; if (dp !== 1'b1) $display("FAIL reset_dp got=%b exp=1", dp); else passes++;
    reset_c = 1'b0;
    restart_model();
    repeat (4 * RD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL first_scan e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
  endtask

  task automatic test_display();
    {min_tens, min_ones, sec_tens, sec_ones} = {4'd1, 4'd2, 4'd3, 4'd4};
    repeat (12 * RD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL display_1234 e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
  endtask

  task automatic test_tearing();
    for (int k = 0; k < 4 * RD && ((e / RD) % 4) != 1; k++) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL tear_align e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    sec_ones = 4'd5;
    min_tens = 4'd7;   // shown later in this same frame, must stay 1 until next frame
    repeat (10 * RD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL tearing e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    min_tens = 4'd1;
    sec_ones = 4'd4;
  endtask

  task automatic test_blink();
    bit found = 0;
    ADJ = 1'b1;
    SEL = 2'b10;
    repeat (4 * BD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL blink e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    // reach a cycle where the selected slot is blanked and stays blanked one more edge
    for (int k = 0; k < 5 * BD && !found; k++) begin
      if (blank_next() && (e % RD) != RD - 1 && (j % BD) != BD - 1) found = 1;
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL blink_seek e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    checks++;
    if (!found || seg !== 7'b1111111) $display("FAIL blink_blank_reached got=%b exp=1111111", seg);
    else passes++;
    ADJ = 1'b0;
    repeat (2 * RD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL adj_drop e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
  endtask

  task automatic test_invalid_bcd();
    sec_tens = 4'd12;
    repeat (12 * RD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL invalid_bcd e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    sec_tens = 4'd3;
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    ADJ = 1'b1;
    SEL = 2'b10;
    for (int k = 0; k < 8 * BD && !found; k++) begin
      if (blank_next() && (e % RD) != RD - 1) found = 1;
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL mid_seek e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    checks++;
    if (!found || an !== 4'b1011 || seg !== 7'b1111111) $display("FAIL mid_blank_reached got=%b_%b exp=1011_1111111", an, seg);
    else passes++;
    reset_c = 1'b1;
    #1;
    checks++; if (an !== 4'b1111) $display("FAIL midreset_an got=%b exp=1111", an); else passes++;
    checks++; if (seg !== 7'b1111111) $display("FAIL midreset_seg got=%b exp=1111111", seg); else passes++;
    checks++; if (dp !== 1'b1) $display("FAIL midreset_dp got=%b exp=1", dp); else passes++;
    repeat (2) @(posedge clk_c);
    #1;
    reset_c = 1'b0;
    restart_model();
    repeat (3 * BD) begin
      tick(); x = q.pop_front(); checks++;
      if ({an, seg, dp} !== x) $display("FAIL after_reset e=%0d got=%b_%b_%b exp=%b", e, an, seg, dp, x);
      else passes++;
    end
    ADJ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_display();
    test_tearing();
    test_blink();
    test_invalid_bcd();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
